// File: rtl/rv_decode_pkg.sv
// Shared types for the RISC-V decode stage: opcodes, format codes, stage states and the decoded bundle.
// The optional illegal-instruction flag is compiled in with RV_DECODE_ILLEGAL_EN.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // FMT_R must stay the zero encoding: register resets rely on it
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
`ifdef RV_DECODE_ILLEGAL_EN
        logic       illegal;
`endif
    } dec_fields_t;

`ifdef RV_DECODE_ILLEGAL_EN
    // A non-11 low opcode pair never matches a listed opcode, so it lands in the default arm
    function automatic logic is_illegal(input logic [31:0] instr);
        logic bad;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE,
            OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL:
                bad = 1'b0;
            OPC_OP:
                bad = !((instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000));
            default:
                bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// out_illegal exists only with RV_DECODE_ILLEGAL_EN.
interface rv_decode_if
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) ();

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
`ifdef RV_DECODE_ILLEGAL_EN
    logic            out_illegal;
`endif

    // slave: the decode stage; master: fetch + execute around it
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_fmt
`ifdef RV_DECODE_ILLEGAL_EN
        , output out_illegal
`endif
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_fmt
`ifdef RV_DECODE_ILLEGAL_EN
        , input out_illegal
`endif
    );

endinterface

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and immediate generator for the RV base instruction formats.
// The immediate is built at 32 bits and sign-extended from instr[31] to XLEN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [31:0] imm32;

    always_comb begin
        fmt   = FMT_R;
        imm32 = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage: output register plus one skid slot so in_ready comes from a flop.
// Define RV_DECODE_ILLEGAL_EN to carry an illegal-instruction flag with each entry.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    rv_decode_if.slave   bus
);

    stage_state_e    state_reg, state_next;
    logic            in_ready_reg, in_ready_next;
    logic            out_valid_reg, out_valid_next;

    dec_fields_t     out_fields_reg, out_fields_next;
    logic [XLEN-1:0] out_imm_reg, out_imm_next;
    logic [PC_W-1:0] out_pc_reg, out_pc_next;

    dec_fields_t     skid_fields_reg, skid_fields_next;
    logic [XLEN-1:0] skid_imm_reg, skid_imm_next;
    logic [PC_W-1:0] skid_pc_reg, skid_pc_next;

    dec_fields_t     dec_fields;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            in_fire;
    logic            out_fire;

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (bus.in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    always_comb begin
        dec_fields         = '0;
        dec_fields.opcode  = bus.in_instr[6:0];
        dec_fields.rd      = bus.in_instr[11:7];
        dec_fields.funct3  = bus.in_instr[14:12];
        dec_fields.rs1     = bus.in_instr[19:15];
        dec_fields.rs2     = bus.in_instr[24:20];
        dec_fields.funct7  = bus.in_instr[31:25];
        dec_fields.fmt     = dec_fmt;
`ifdef RV_DECODE_ILLEGAL_EN
        dec_fields.illegal = is_illegal(bus.in_instr);
`endif
    end

    assign in_fire  = bus.in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && bus.out_ready;

    always_comb begin
        state_next       = state_reg;
        out_fields_next  = out_fields_reg;
        out_imm_next     = out_imm_reg;
        out_pc_next      = out_pc_reg;
        skid_fields_next = skid_fields_reg;
        skid_imm_next    = skid_imm_reg;
        skid_pc_next     = skid_pc_reg;

        if (bus.flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_fields_next = dec_fields;
                        out_imm_next    = dec_imm;
                        out_pc_next     = bus.in_pc;
                        state_next      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_fields_next = dec_fields;
                        out_imm_next    = dec_imm;
                        out_pc_next     = bus.in_pc;
                    end else if (in_fire) begin
                        // Output slot is stalled: park the new entry behind it
                        skid_fields_next = dec_fields;
                        skid_imm_next    = dec_imm;
                        skid_pc_next     = bus.in_pc;
                        state_next       = ST_FULL;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_fire) begin
                        out_fields_next = skid_fields_reg;
                        out_imm_next    = skid_imm_reg;
                        out_pc_next     = skid_pc_reg;
                        state_next      = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end

        in_ready_next  = (state_next != ST_FULL);
        out_valid_next = (state_next != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_EMPTY;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            out_fields_reg  <= '0;
            out_imm_reg     <= '0;
            out_pc_reg      <= '0;
            skid_fields_reg <= '0;
            skid_imm_reg    <= '0;
            skid_pc_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            in_ready_reg    <= in_ready_next;
            out_valid_reg   <= out_valid_next;
            out_fields_reg  <= out_fields_next;
            out_imm_reg     <= out_imm_next;
            out_pc_reg      <= out_pc_next;
            skid_fields_reg <= skid_fields_next;
            skid_imm_reg    <= skid_imm_next;
            skid_pc_reg     <= skid_pc_next;
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_pc      = out_pc_reg;
    assign bus.out_opcode  = out_fields_reg.opcode;
    assign bus.out_rd      = out_fields_reg.rd;
    assign bus.out_funct3  = out_fields_reg.funct3;
    assign bus.out_rs1     = out_fields_reg.rs1;
    assign bus.out_rs2     = out_fields_reg.rs2;
    assign bus.out_funct7  = out_fields_reg.funct7;
    assign bus.out_imm     = out_imm_reg;
    assign bus.out_fmt     = out_fields_reg.fmt;
`ifdef RV_DECODE_ILLEGAL_EN
    assign bus.out_illegal = out_fields_reg.illegal;
`endif

endmodule
